// File: rtl/ntt_butterfly_core.sv
// ntt_butterfly_core
//   Radix-2 NTT/INTT butterfly wrapped around an external fixed-latency
//   modular multiplier (q = 12289 by default, 14-bit coefficients).
//   Stage S0 registers the transaction. The operand mux feeds the multiplier.
//   A delay line carries the companion value alongside the product. The post
//   stage does the modular add/sub. Results land in an output FIFO, and
//   credits are reserved at accept time so the multiplier never has to stall.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input handshake; in_ready depends only on registered counts
//   mode            0 = Cooley-Tukey (NTT), 1 = Gentleman-Sande (INTT)
//   a, b, w         coefficients and twiddle, each < q
//   mul_a, mul_b    operands to the external multiplier (0 when S0 is empty)
//   mul_c           product mul_a*mul_b mod q, returned MUL_LAT cycles later
//   out_valid/ready output handshake on the FIFO head (first-word fall-through)
//   out0, out1      butterfly results at the FIFO head (0 when empty)
//   idle            nothing in flight and FIFO empty

module ntt_butterfly_core #(
    parameter int data_width = 14,
    parameter int q          = 12289,
    parameter int MUL_LAT    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mode,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [data_width-1:0] w,
    output logic [data_width-1:0] mul_a,
    output logic [data_width-1:0] mul_b,
    input  logic [data_width-1:0] mul_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out0,
    output logic [data_width-1:0] out1,
    output logic                  idle
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [data_width:0] Q_EXT     = (data_width + 1)'(q);
    localparam logic [CNT_W:0]      DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    // One extra bit holds the carry or borrow. A single correction step is
    // enough because both operands are already reduced.
    function automatic logic [data_width-1:0] mod_add(
        input logic [data_width-1:0] x,
        input logic [data_width-1:0] y
    );
        logic [data_width:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_EXT) s = s - Q_EXT;
        return s[data_width-1:0];
    endfunction

    function automatic logic [data_width-1:0] mod_sub(
        input logic [data_width-1:0] x,
        input logic [data_width-1:0] y
    );
        logic [data_width:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[data_width]) d = d + Q_EXT;
        return d[data_width-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Handshake and credit bookkeeping
    // ------------------------------------------------------------------
    logic                 accept;
    logic                 fifo_wr;
    logic                 fifo_rd;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     fifo_count;

    assign accept = in_valid & in_ready;

    // Every accepted transaction holds a credit until it is read from the
    // FIFO, so the FIFO cannot overflow even with out_ready held low.
    assign in_ready  = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_EXT;
    assign out_valid = (fifo_count != '0);
    assign fifo_rd   = out_valid & out_ready;
    assign idle      = (inflight == '0) & (fifo_count == '0);

    // ------------------------------------------------------------------
    // S0 register and delay line.
    // vld_pipe[0] is S0. vld_pipe[MUL_LAT] lines up with mul_c.
    // ------------------------------------------------------------------
    logic [MUL_LAT:0]                  vld_pipe;
    logic [data_width-1:0]             a_r, b_r, w_r;
    logic                              mode_r;
    logic [MUL_LAT:1]                  mode_pipe;
    logic [MUL_LAT:1][data_width-1:0]  side_pipe;
    logic [data_width-1:0]             side_s0;

    // Operand mux. CT multiplies b by the twiddle. GS multiplies (a - b) by
    // the twiddle. The side value is what the post stage combines with the
    // product.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        side_s0 = '0;
        if (vld_pipe[0]) begin
            mul_b = w_r;
            if (mode_r) begin
                mul_a   = mod_sub(a_r, b_r);
                side_s0 = mod_add(a_r, b_r);
            end else begin
                mul_a   = b_r;
                side_s0 = a_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            a_r       <= '0;
            b_r       <= '0;
            w_r       <= '0;
            mode_r    <= 1'b0;
            mode_pipe <= '0;
            side_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MUL_LAT-1:0], accept};
            if (accept) begin
                a_r    <= a;
                b_r    <= b;
                w_r    <= w;
                mode_r <= mode;
            end
            mode_pipe[1] <= mode_r;
            side_pipe[1] <= side_s0;
            for (int i = 2; i <= MUL_LAT; i++) begin
                mode_pipe[i] <= mode_pipe[i-1];
                side_pipe[i] <= side_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Post stage: combine the delay-line head with mul_c in the same cycle.
    // ------------------------------------------------------------------
    logic [data_width-1:0] head_side;
    logic                  head_mode;
    logic [data_width-1:0] res0, res1;

    assign head_side = side_pipe[MUL_LAT];
    assign head_mode = mode_pipe[MUL_LAT];
    assign fifo_wr   = vld_pipe[MUL_LAT];

    always_comb begin
        if (head_mode) begin
            res0 = head_side;
            res1 = mul_c;
        end else begin
            res0 = mod_add(head_side, mul_c);
            res1 = mod_sub(head_side, mul_c);
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight   <= '0;
            fifo_count <= '0;
        end else begin
            inflight   <= inflight + CNT_W'(accept) - CNT_W'(fifo_wr);
            fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: circular buffer. The head is muxed straight to the
    // outputs. Outputs are forced to 0 when empty, so the storage itself
    // needs no reset.
    // ------------------------------------------------------------------
    logic [data_width-1:0] mem0 [FIFO_DEPTH];
    logic [data_width-1:0] mem1 [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (fifo_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem0[wr_ptr] <= res0;
            mem1[wr_ptr] <= res1;
        end
    end

    assign out0 = out_valid ? mem0[rd_ptr] : '0;
    assign out1 = out_valid ? mem1[rd_ptr] : '0;

endmodule

// File: tb/tb_ntt_butterfly_core.sv
// Scoreboard bench for ntt_butterfly_core.
// The bench models the external multiplier as a MUL_LAT-deep product
// pipeline. A driver pushes expected results when a transaction is accepted.
// A monitor on the falling edge pops and compares every consumed output.
module tb_ntt_butterfly_core;

    localparam int DW    = 14;
    localparam int Q     = 12289;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, mode;
    logic [DW-1:0] a, b, w;
    logic [DW-1:0] mul_a, mul_b, mul_c;
    logic          out_valid, out_ready;
    logic [DW-1:0] out0, out1;
    logic          idle;

    ntt_butterfly_core #(
        .data_width(DW), .q(Q), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .w(w),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External modular multiplier: fixed latency, no stall.
    logic [DW-1:0] mp [LAT] = '{default: '0};
    always @(posedge clk) begin
        mp[0] <= DW'((int'(mul_a) * int'(mul_b)) % Q);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_c = mp[LAT-1];

    typedef struct {
        int a; int b; int w; int m;
        int e0; int e1; bit has_exp;
    } item_t;
    typedef struct { int e0; int e1; int edge_n; } exp_t;

    item_t pend[$];
    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    n_out = 0;
    int    ready_lows = 0;
    bit    lat_chk = 0;
    bit    stream = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Butterfly reference computed directly from its definition.
    function automatic void ref_bfly(input int ra, input int rb, input int rw,
                                     input int rm, output int o0, output int o1);
        int t;
        if (rm == 0) begin
            t  = (rb * rw) % Q;
            o0 = (ra + t) % Q;
            o1 = (ra - t + Q) % Q;
        end else begin
            o0 = (ra + rb) % Q;
            o1 = (((ra - rb + Q) % Q) * rw) % Q;
        end
    endfunction

    // Monitor: every consumed head must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("unexpected_output_count", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out0", int'(out0), e.e0);
                chk("out1", int'(out1), e.e1);
                if (lat_chk) chk("out_cycle_after_accept", cyc - e.edge_n, LAT + 1);
            end
        end
    end

    // Offer pending items back to back. Called at #1 after a rising edge.
    task automatic offer(input int budget, output int acc, output int used);
        item_t it;
        int    e0, e1;
        acc  = 0;
        used = 0;
        while (pend.size() > 0 && used < budget) begin
            it       = pend[0];
            in_valid = 1'b1;
            a        = DW'(it.a);
            b        = DW'(it.b);
            w        = DW'(it.w);
            mode     = it.m[0];
            @(negedge clk);
            used++;
            if (stream && !in_ready) ready_lows++;
            if (in_ready) begin
                if (it.has_exp) begin
                    e0 = it.e0;
                    e1 = it.e1;
                end else begin
                    ref_bfly(it.a, it.b, it.w, it.m, e0, e1);
                end
                sb.push_back('{e0, e1, cyc + 1});
                it = pend.pop_front();
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !idle) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(sb.size() == 0 && idle), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_dir(input int ra, input int rb, input int rw, input int rm,
                            input int e0, input int e1);
        pend.push_back('{ra, rb, rw, rm, e0, e1, 1'b1});
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            pend.push_back('{int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)),
                             int'($urandom_range(Q - 1, 0)), int'($urandom_range(1, 0)),
                             0, 0, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, used, n0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        a = '0; b = '0; w = '0;
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_idle", int'(idle), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_mul_a", int'(mul_a), 0);
        chk("reset_mul_b", int'(mul_b), 0);
        chk("reset_out0", int'(out0), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed CT/GS vectors, including the wrap corners.
        lat_chk = 1'b1;
        push_dir(5, 3, 4, 0, 17, 12282);
        push_dir(12288, 1, 1, 0, 0, 12287);
        push_dir(0, 1, 1, 0, 1, 12288);
        push_dir(100, 300, 2, 1, 400, 11889);
        offer(50, acc, used);
        chk("directed_accepted", acc, 4);
        wait_drain("directed_drain", 50);

        // Back-pressure: only DEPTH credits are available while the
        // output is blocked.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        n0        = n_out;
        push_rand(12);
        offer(30, acc, used);
        chk("bp_accepted", acc, DEPTH);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        offer(40, acc, used);
        chk("bp_rest_accepted", acc, 12 - DEPTH);
        wait_drain("bp_drain", 60);
        chk("bp_outputs", n_out - n0, 12);

        // Reset with 2 results buffered and 3 still in flight.
        out_ready = 1'b0;
        push_rand(5);
        offer(10, acc, used);
        chk("rst_test_accepted", acc, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_out_valid", int'(out_valid), 1);
        chk("pre_reset_idle", int'(idle), 0);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_idle", int'(idle), 1);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out0", int'(out0), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        n0        = n_out;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_no_outputs", n_out - n0, 0);
        chk("post_reset_idle", int'(idle), 1);

        // Streaming: 200 random mixed-mode items, no bubbles, fixed latency.
        lat_chk    = 1'b1;
        stream     = 1'b1;
        ready_lows = 0;
        n0         = n_out;
        push_rand(200);
        offer(400, acc, used);
        stream = 1'b0;
        chk("stream_accepted", acc, 200);
        chk("stream_cycles", used, 200);
        chk("stream_in_ready_lows", ready_lows, 0);
        wait_drain("stream_drain", 40);
        chk("stream_outputs", n_out - n0, 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
